hdr_pkt_builder: RTL and testbench

Source-side packet builder for mesh terminal agents. It accepts per-field header requests on a valid/ready interface and packs them into PCK_SZ-bit packets using the hdr_map_pkg bit map. It buffers the packets in a first-word-fall-through (FWFT) FIFO and presents them to the router terminal input with the pndng/data_out/popin handshake. It is the encoding counterpart of the header decode used by the scoreboard.

---
 rtl/hdr_map_pkg.sv | 51 +++++
 rtl/hdr_fwft_fifo.sv | 61 ++++++
 rtl/hdr_pkt_builder.sv | 103 ++++++++++
 tb/tb_hdr_pkt_builder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hdr_map_pkg.sv
// Header bit map, field widths and packing helper for mesh packets.
// Bit positions assume the 40-bit header sits at the top of the packet.
package hdr_map_pkg;

  localparam int HDR_PCK_SZ = 40;

  localparam int NXT_JUMP_W = 8;
  localparam int RC_W       = 4;
  localparam int TERM_W     = 6;
  localparam int ID_W       = 9;

  localparam int NXT_JUMP_MSB = 39;
  localparam int NXT_JUMP_LSB = 32;
  localparam int TRGT_R_MSB   = 31;
  localparam int TRGT_R_LSB   = 28;
  localparam int TRGT_C_MSB   = 27;
  localparam int TRGT_C_LSB   = 24;
  localparam int MODE_BIT     = 23;
  localparam int SRC_MSB      = 22;
  localparam int SRC_LSB      = 17;
  localparam int DST_MSB      = 16;
  localparam int DST_LSB      = 11;
  localparam int ID_MSB       = 10;
  localparam int ID_LSB       = 2;

  typedef struct packed {
    logic [NXT_JUMP_W-1:0] nxt_jump;
    logic [RC_W-1:0]       trgt_r;
    logic [RC_W-1:0]       trgt_c;
    logic                  mode;
    logic [TERM_W-1:0]     src;
    logic [TERM_W-1:0]     dst;
    logic [ID_W-1:0]       id;
  } hdr_fields_t;

  function automatic logic [HDR_PCK_SZ-1:0] pack_hdr(
    input hdr_fields_t f
  );
    logic [HDR_PCK_SZ-1:0] p;
    p = '0;
    p[NXT_JUMP_MSB:NXT_JUMP_LSB] = f.nxt_jump;
    p[TRGT_R_MSB:TRGT_R_LSB]     = f.trgt_r;
    p[TRGT_C_MSB:TRGT_C_LSB]     = f.trgt_c;
    p[MODE_BIT]                  = f.mode;
    p[SRC_MSB:SRC_LSB]           = f.src;
    p[DST_MSB:DST_LSB]           = f.dst;
    p[ID_MSB:ID_LSB]             = f.id;
    return p;
  endfunction

endpackage

// File: rtl/hdr_fwft_fifo.sv
// First-word-fall-through packet FIFO with occupancy count.
// Push when full and pop when empty are ignored internally.
module hdr_fwft_fifo
  import hdr_map_pkg::*;
#(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hdr_pkt_builder.sv
// Packs header requests into packets and queues them for the router.
// Optional HDR_AUTO_ID_EN replaces in_id with an internal id counter.
module hdr_pkt_builder
  import hdr_map_pkg::*;
#(
  parameter int PCK_SZ = 40,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_trgt_r,
  input  logic [3:0]        in_trgt_c,
  input  logic              in_mode,
  input  logic [5:0]        in_src,
  input  logic [5:0]        in_dst,
  input  logic [8:0]        in_id,
  output logic [PCK_SZ-1:0] data_out,
  output logic              pndng,
  input  logic              popin,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  hdr_fields_t           fields;
  logic [HDR_PCK_SZ-1:0] hdr;
  logic [PCK_SZ-1:0]     pkt;
  logic [PCK_SZ-1:0]     head;
  logic [ID_W-1:0]       id_sel;
  logic                  accept;
  logic                  full;
  logic                  empty;
  logic [AW:0]           count;

`ifdef HDR_AUTO_ID_EN
  logic [ID_W-1:0] id_q;
  logic            unused_in_id;

  assign unused_in_id = ^in_id;
  assign id_sel       = id_q;

  always_ff @(posedge clk) begin
    if (reset)
      id_q <= '0;
    else if (!flush && accept)
      id_q <= id_q + 1'b1;
  end
`else
  assign id_sel = in_id;
`endif

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign pndng    = !empty;
  assign data_out = pndng ? head : '0;

  always_comb begin
    fields          = '0;
    fields.trgt_r   = in_trgt_r;
    fields.trgt_c   = in_trgt_c;
    fields.mode     = in_mode;
    fields.src      = in_src;
    fields.dst      = in_dst;
    fields.id       = id_sel;
    hdr             = pack_hdr(fields);
    pkt             = '0;
    pkt[PCK_SZ-1 -: HDR_PCK_SZ] = hdr;
  end

  hdr_fwft_fifo #(
    .W     (PCK_SZ),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (accept),
    .pop   (popin),
    .wdata (pkt),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt   <= '0;
      underflow <= 1'b0;
    end else if (flush) begin
      pkt_cnt   <= '0;
    end else if (popin) begin
      if (pndng) pkt_cnt   <= pkt_cnt + 1'b1;
      else       underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdr_pkt_builder.sv
// Self-checking bench for hdr_pkt_builder against a queue reference model.
// Honors HDR_AUTO_ID_EN in both the model and the id sweep.
module tb_hdr_pkt_builder;

  localparam int PCK_SZ = 40;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;

  logic              clk = 0;
  logic              reset, flush, in_valid, in_ready, in_mode, pndng, popin;
  logic [3:0]        in_trgt_r, in_trgt_c;
  logic [5:0]        in_src, in_dst;
  logic [8:0]        in_id;
  logic [PCK_SZ-1:0] data_out;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              underflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] q [$];
  int          m_cnt;
  bit          m_uf;
  int          m_id;

  always #5 clk = ~clk;

  hdr_pkt_builder #(.PCK_SZ(PCK_SZ), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_trgt_r(in_trgt_r), .in_trgt_c(in_trgt_c), .in_mode(in_mode),
    .in_src(in_src), .in_dst(in_dst), .in_id(in_id),
    .data_out(data_out), .pndng(pndng), .popin(popin),
    .pkt_cnt(pkt_cnt), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_pkt(int r, int c, int m, int s,
                                            int d, int id);
    logic [63:0] v;
    v = 64'(r) * (64'd1 << 28) + 64'(c) * (64'd1 << 24)
      + 64'(m) * (64'd1 << 23) + 64'(s) * (64'd1 << 17)
      + 64'(d) * (64'd1 << 11) + 64'(id) * 64'd4;
    return v << (PCK_SZ - 40);
  endfunction

  task automatic model_edge();
    int  sz;
    int  idv;
    bit  acc;
    sz = q.size();
    if (reset) begin
      q.delete(); m_cnt = 0; m_uf = 0; m_id = 0;
    end else if (flush) begin
      q.delete(); m_cnt = 0;
    end else begin
      acc = in_valid && (sz != DEPTH);
`ifdef HDR_AUTO_ID_EN
      idv = m_id;
`else
      idv = int'(in_id);
`endif
      if (popin && sz == 0) m_uf = 1;
      if (popin && sz != 0) begin
        void'(q.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      if (acc) begin
        q.push_back(model_pkt(in_trgt_r, in_trgt_c, in_mode,
                              in_src, in_dst, idv));
        m_id = (m_id + 1) % 512;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("pndng", 64'(pndng), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    chk("data_out", 64'(data_out), q.size() != 0 ? q[0] : 64'd0);
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
    chk("underflow", 64'(underflow), 64'(m_uf));
  endtask

  task automatic rnd_fields();
    in_trgt_r = 4'($urandom);
    in_trgt_c = 4'($urandom);
    in_mode   = 1'($urandom);
    in_src    = 6'($urandom);
    in_dst    = 6'($urandom);
    in_id     = 9'($urandom);
  endtask

  task automatic idle();
    in_valid = 0; popin = 0; flush = 0; reset = 0;
  endtask

  initial begin
    idle();
    rnd_fields();
    reset = 1;
    cycle();
    reset = 0;
    cycle();
    chk("rst_pndng", 64'(pndng), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_data", 64'(data_out), 64'd0);

    in_trgt_r = 4'd2; in_trgt_c = 4'd3; in_mode = 1'b1;
    in_src = 6'h05; in_dst = 6'h0A; in_id = 9'h1A3;
    in_valid = 1;
    cycle();
    in_valid = 0;
`ifdef HDR_AUTO_ID_EN
    chk("pack_lit", 64'(data_out), 64'h00238A5000);
`else
    chk("pack_lit", 64'(data_out), 64'h00238A568C);
`endif
    popin = 1;
    cycle();
    popin = 0;
    chk("pop_pndng", 64'(pndng), 64'd0);
    chk("pop_cnt", 64'(pkt_cnt), 64'd1);

    for (int i = 0; i < 4; i++) begin
      rnd_fields(); in_valid = 1; cycle();
    end
    chk("full_ready", 64'(in_ready), 64'd0);
    rnd_fields();
    cycle();
    chk("full_refuse", 64'(q.size()), 64'd4);
    popin = 1;
    cycle();
    in_valid = 0; popin = 0;
    chk("full_pop_ready", 64'(in_ready), 64'd1);
    popin = 1;
    repeat (3) cycle();
    popin = 0;

    for (int i = 1; i <= 4; i++) begin
      rnd_fields(); in_id = 9'(i);
      in_valid = 1;
      popin = (i > 2);
      cycle();
      if (i >= 2) chk("stream_level", 64'(q.size()), 64'd2);
    end
    in_valid = 0; popin = 1;
    repeat (2) cycle();
    popin = 0;
    chk("stream_drained", 64'(pndng), 64'd0);

    popin = 1;
    cycle();
    chk("uf_set", 64'(underflow), 64'd1);
    popin = 0;
    cycle();
    chk("uf_sticky", 64'(underflow), 64'd1);
    rnd_fields(); in_valid = 1; popin = 1;
    cycle();
    in_valid = 0; popin = 0;
    chk("uf_push_kept", 64'(pndng), 64'd1);

    in_valid = 1;
    repeat (2) begin rnd_fields(); cycle(); end
    in_valid = 0; flush = 1;
    cycle();
    flush = 0;
    chk("flush_pndng", 64'(pndng), 64'd0);
    chk("flush_cnt", 64'(pkt_cnt), 64'd0);
    in_valid = 1;
    repeat (2) begin rnd_fields(); cycle(); end
    reset = 1;
    cycle();
    reset = 0; in_valid = 0;
    chk("rst_mid_pndng", 64'(pndng), 64'd0);
    chk("rst_mid_uf", 64'(underflow), 64'd0);

    for (int i = 0; i < 400; i++) begin
      rnd_fields();
      in_valid = 1'($urandom_range(0, 99) < 60);
      popin    = 1'($urandom_range(0, 99) < 45);
      flush    = 1'($urandom_range(0, 99) < 3);
      cycle();
    end
    idle();

`ifdef HDR_AUTO_ID_EN
    reset = 1;
    cycle();
    reset = 0;
    in_valid = 1; popin = 1;
    for (int i = 0; i < 513; i++) begin
      rnd_fields();
      cycle();
    end
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
